led_seven_segment_reader: RTL and testbench
===========================================

LED_SEVEN_SEGMENT_READER -- requirements
Module: led_seven_segment_reader

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of scanned digits (2..8).
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, consecutive identical samples needed to accept a digit (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sample_valid  input  1  leds/digit_index carry a sample this cycle.
REQ-006 SHALL have port digit_index  input  3  digit being sampled; values >= NUM_DIGITS ignored.
REQ-007 SHALL have port leds  input  7  segments a-g on bits 0-6, 1 = lit.
REQ-008 SHALL have port report_valid  output  1  report holding register full.
REQ-009 SHALL have port report_ack  input  1  consumer accepts report when report_valid high.
REQ-010 SHALL have port report_digit  output  3  digit index of report.
REQ-011 SHALL have port report_hex  output  4  decoded hex value; 0 when report_error set.
REQ-012 SHALL have port report_error  output  1  accepted pattern matches no hex symbol.
REQ-013 SHALL have port overrun  output  1  sticky: a report was dropped while holding register full.

Function
REQ-014 SHALL decode patterns with the canonical table: 0=7'h3F, 1=7'h06, 2=7'h5B, 8=7'h7F, A=7'h77, all 16 symbols from the shared package; any other pattern is an error.
REQ-015 SHALL keep per digit: last sampled pattern (7b), match counter (4b, saturating at STABLE_SAMPLES), last reported pattern (7b), reported flag.
REQ-016 On valid sample equal to the digit's last sampled pattern, SHALL increment that digit's counter (saturate); otherwise SHALL store the pattern and set counter to 1.
REQ-017 SHALL accept a pattern for a digit on the sample where its counter reaches STABLE_SAMPLES (STABLE_SAMPLES=1: same sample) and pattern differs from last reported, or the digit has never reported.
REQ-018 On acceptance, SHALL update last reported pattern regardless of whether the report is delivered.
REQ-019 Accepted report SHALL appear on report_* exactly one cycle after the accepting sample edge.
REQ-020 report_valid SHALL remain high with report_* stable until the cycle after report_ack is sampled high.
REQ-021 Acceptance while report_valid high and report_ack low SHALL drop the new report and set overrun; held report is unchanged.
REQ-022 Acceptance in the same cycle as report_ack with report_valid high SHALL load the new report (no gap, no overrun).
REQ-023 overrun SHALL clear only on reset.
REQ-024 Samples with digit_index >= NUM_DIGITS SHALL change no state.

Reset
REQ-025 reset SHALL clear report_valid, report_digit, report_hex, report_error, overrun, all counters and reported flags, and set all stored patterns to 7'h00.
REQ-026 reset asserted mid-stability-count or with report held SHALL discard it; no report emitted for samples taken in a reset cycle.

Configuration
REQ-027 With LED_SEVEN_SEGMENT_READER_BLANK_EN defined, pattern 7'h00 SHALL be accepted as blank: report_error=0, report_hex=0, extra output report_blank=1.
REQ-028 Without LED_SEVEN_SEGMENT_READER_BLANK_EN, 7'h00 SHALL be reported as an error and report_blank SHALL not exist.

Structure
REQ-029 Shared package SHALL hold the 16-entry segment pattern constants, blank pattern constant, and segment bit-index constants.
REQ-030 SHALL instance one combinational sub-module led_seven_segment_decode (7b pattern in; hex, error, blank out).

Verification
REQ-031 STABLE_SAMPLES=4, digit 1 sampled 7'h06 x4 -> one report digit=1 hex=1 error=0, cycle after 4th sample.
REQ-032 Digit 0: 7'h5B x3, 7'h3F x1, 7'h5B x3 -> no report; 4th 7'h5B -> report hex=2.
REQ-033 Digit 2: 7'h7F x4, no ack, digit 3: 7'h77 x4 -> report stays hex=8 digit=2, overrun=1.
REQ-034 Report held, ack asserted in the cycle the 4th 7'h77 for digit 3 arrives -> next cycle report hex=A digit=3, overrun=0.
REQ-035 Digit 0: 7'h00 x4 -> error=1 hex=0 without macro; blank=1 error=0 with LED_SEVEN_SEGMENT_READER_BLANK_EN.
REQ-036 Reset after 3 matching samples, then 1 more -> no report; 4 further samples -> report.

Source files
------------

// File: rtl/led_seven_segment_reader_pkg.sv
// Shared seven-segment constants: segment bit positions, the 16 hex glyphs and the blank glyph.
// Segment a..g map to bits 0..6; a set bit means the segment is lit.
package led_seven_segment_reader_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/led_seven_segment_decode.sv
// Combinational seven-segment pattern to hex decoder.
// Optional macro LED_SEVEN_SEGMENT_READER_BLANK_EN: the all-dark pattern decodes as blank instead of error.
module led_seven_segment_decode
    import led_seven_segment_reader_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] hex_o,
    output logic       error_o,
    output logic       blank_o
);

    always_comb begin
        hex_o   = 4'h0;
        error_o = 1'b0;
        blank_o = 1'b0;
        case (pattern_i)
            SEG_HEX_0: hex_o = 4'h0;
            SEG_HEX_1: hex_o = 4'h1;
            SEG_HEX_2: hex_o = 4'h2;
            SEG_HEX_3: hex_o = 4'h3;
            SEG_HEX_4: hex_o = 4'h4;
            SEG_HEX_5: hex_o = 4'h5;
            SEG_HEX_6: hex_o = 4'h6;
            SEG_HEX_7: hex_o = 4'h7;
            SEG_HEX_8: hex_o = 4'h8;
            SEG_HEX_9: hex_o = 4'h9;
            SEG_HEX_A: hex_o = 4'hA;
            SEG_HEX_B: hex_o = 4'hB;
            SEG_HEX_C: hex_o = 4'hC;
            SEG_HEX_D: hex_o = 4'hD;
            SEG_HEX_E: hex_o = 4'hE;
            SEG_HEX_F: hex_o = 4'hF;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
            SEG_BLANK: blank_o = 1'b1;
`endif
            default:   error_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/led_seven_segment_reader.sv
// Debounces scanned seven-segment digits and reports each newly stable glyph through a one-deep holding register.
// Optional macro LED_SEVEN_SEGMENT_READER_BLANK_EN adds report_blank and treats 7'h00 as a valid blank digit.
module led_seven_segment_reader
    import led_seven_segment_reader_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [2:0] digit_index,
    input  logic [6:0] leds,
    output logic       report_valid,
    input  logic       report_ack,
    output logic [2:0] report_digit,
    output logic [3:0] report_hex,
    output logic       report_error,
    output logic       overrun
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
    ,
    output logic       report_blank
`endif
);

    localparam logic [3:0] STABLE  = 4'(STABLE_SAMPLES);
    localparam logic [3:0] NDIGITS = 4'(NUM_DIGITS);

    // Per-digit tracking; sized for the full 3-bit index space, only NUM_DIGITS entries are ever written.
    logic [6:0] last_pat_q [8];
    logic [3:0] cnt_q      [8];
    logic [6:0] rep_pat_q  [8];
    logic [7:0] reported_q;

    logic       report_valid_q, report_valid_d;
    logic [2:0] report_digit_q, report_digit_d;
    logic [3:0] report_hex_q,   report_hex_d;
    logic       report_error_q, report_error_d;
    logic       overrun_q,      overrun_d;

    logic       in_range;
    logic       match;
    logic       reach;
    logic       accept;
    logic [3:0] cnt_cur;
    logic [3:0] cnt_next;

    logic [3:0] dec_hex;
    logic       dec_error;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
    logic       dec_blank;
    logic       report_blank_q, report_blank_d;
`else
    logic       dec_blank_unused;
`endif

    led_seven_segment_decode u_decode (
        .pattern_i (leds),
        .hex_o     (dec_hex),
        .error_o   (dec_error),
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
        .blank_o   (dec_blank)
`else
        .blank_o   (dec_blank_unused)
`endif
    );

    always_comb begin
        in_range = sample_valid && ({1'b0, digit_index} < NDIGITS);
        cnt_cur  = cnt_q[digit_index];
        match    = (leds == last_pat_q[digit_index]);
        if (!match) begin
            cnt_next = 4'd1;
        end else if (cnt_cur >= STABLE) begin
            cnt_next = STABLE;
        end else begin
            cnt_next = cnt_cur + 4'd1;
        end
        // Only the transition into STABLE counts; a saturated counter must not re-trigger.
        reach  = (cnt_next == STABLE) && !(match && (cnt_cur == STABLE));
        accept = in_range && reach &&
                 (!reported_q[digit_index] || (leds != rep_pat_q[digit_index]));
    end

    always_comb begin
        report_valid_d = report_valid_q;
        report_digit_d = report_digit_q;
        report_hex_d   = report_hex_q;
        report_error_d = report_error_q;
        overrun_d      = overrun_q;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
        report_blank_d = report_blank_q;
`endif
        if (accept) begin
            if (!report_valid_q || report_ack) begin
                report_valid_d = 1'b1;
                report_digit_d = digit_index;
                report_hex_d   = dec_hex;
                report_error_d = dec_error;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
                report_blank_d = dec_blank;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (report_valid_q && report_ack) begin
            report_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                last_pat_q[i] <= SEG_BLANK;
                cnt_q[i]      <= 4'd0;
                rep_pat_q[i]  <= SEG_BLANK;
            end
            reported_q     <= '0;
            report_valid_q <= 1'b0;
            report_digit_q <= 3'd0;
            report_hex_q   <= 4'h0;
            report_error_q <= 1'b0;
            overrun_q      <= 1'b0;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
            report_blank_q <= 1'b0;
`endif
        end else begin
            if (in_range) begin
                last_pat_q[digit_index] <= leds;
                cnt_q[digit_index]      <= cnt_next;
                if (accept) begin
                    rep_pat_q[digit_index]  <= leds;
                    reported_q[digit_index] <= 1'b1;
                end
            end
            report_valid_q <= report_valid_d;
            report_digit_q <= report_digit_d;
            report_hex_q   <= report_hex_d;
            report_error_q <= report_error_d;
            overrun_q      <= overrun_d;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
            report_blank_q <= report_blank_d;
`endif
        end
    end

    assign report_valid = report_valid_q;
    assign report_digit = report_digit_q;
    assign report_hex   = report_hex_q;
    assign report_error = report_error_q;
    assign overrun      = overrun_q;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
    assign report_blank = report_blank_q;
`endif

endmodule

// File: tb/tb_led_seven_segment_reader.sv
// Directed scoreboard bench for led_seven_segment_reader (default parameters, optional blank macro).
module tb_led_seven_segment_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_valid;
    logic [2:0] digit_index;
    logic [6:0] leds;
    logic       report_valid;
    logic       report_ack;
    logic [2:0] report_digit;
    logic [3:0] report_hex;
    logic       report_error;
    logic       overrun;
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
    logic       report_blank;
`endif

    led_seven_segment_reader #(.NUM_DIGITS(4), .STABLE_SAMPLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .digit_index  (digit_index),
        .leds         (leds),
        .report_valid (report_valid),
        .report_ack   (report_ack),
        .report_digit (report_digit),
        .report_hex   (report_hex),
        .report_error (report_error),
        .overrun      (overrun)
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
        ,
        .report_blank (report_blank)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] digit;
        logic [3:0] hex;
        logic       err;
        logic       blank;
    } rep_t;

    rep_t sb[$];
    rep_t cur;
    int   compared   = 0;
    int   mismatched = 0;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [2:0] d, input logic [6:0] p,
                       input logic ack, input logic rst);
        @(negedge clk);
        sample_valid = v;
        digit_index  = d;
        leds         = p;
        report_ack   = ack;
        reset        = rst;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        report_ack   = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic push(input logic [2:0] d, input logic [3:0] h, input logic e, input logic b);
        rep_t r;
        r.digit = d;
        r.hex   = h;
        r.err   = e;
        r.blank = b;
        sb.push_back(r);
    endtask

    task automatic exp_report(input string tag);
        chk({tag, "_valid"}, report_valid, 1'b1);
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL %s_queue observed=empty expected=queued_report", tag);
        end
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk({tag, "_digit"}, report_digit, cur.digit);
            chk({tag, "_hex"},   report_hex,   cur.hex);
            chk({tag, "_err"},   report_error, cur.err);
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
            chk({tag, "_blank"}, report_blank, cur.blank);
`endif
        end
    endtask

    task automatic exp_hold(input string tag);
        chk({tag, "_valid"}, report_valid, 1'b1);
        chk({tag, "_digit"}, report_digit, cur.digit);
        chk({tag, "_hex"},   report_hex,   cur.hex);
        chk({tag, "_err"},   report_error, cur.err);
    endtask

    task automatic exp_none(input string tag);
        chk({tag, "_valid"}, report_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sample_valid = 1'b0; digit_index = 3'd0; leds = 7'h00; report_ack = 1'b0;
        cyc(0, 0, 7'h00, 0, 1);
        cyc(0, 0, 7'h00, 0, 1);
        chk("rst_valid",   report_valid, 1'b0);
        chk("rst_digit",   report_digit, 3'd0);
        chk("rst_hex",     report_hex,   4'h0);
        chk("rst_err",     report_error, 1'b0);
        chk("rst_overrun", overrun,      1'b0);

        // Digit 1 stabilises on "1"
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd1, 7'h06, 0, 0);
            exp_none("d1_pre");
        end
        push(3'd1, 4'h1, 1'b0, 1'b0);
        cyc(1, 3'd1, 7'h06, 0, 0);
        exp_report("d1_rep");
        cyc(0, 0, 7'h00, 0, 0);
        exp_hold("d1_hold");
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("d1_ack");

        // Interrupted run restarts the count
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd0, 7'h5B, 0, 0);
            exp_none("d0_runa");
        end
        cyc(1, 3'd0, 7'h3F, 0, 0);
        exp_none("d0_glitch");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd0, 7'h5B, 0, 0);
            exp_none("d0_runb");
        end
        push(3'd0, 4'h2, 1'b0, 1'b0);
        cyc(1, 3'd0, 7'h5B, 0, 0);
        exp_report("d0_rep");
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("d0_ack");

        // Out-of-range digit indices are ignored
        for (int i = 0; i < 5; i++) begin
            cyc(1, 3'd5, 7'h3F, 0, 0);
            exp_none("oor5");
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, 3'd7, 7'h06, 0, 0);
            exp_none("oor7");
        end

        // Overrun: digit 3 accepted while digit 2 report is held
        for (int i = 0; i < 3; i++) cyc(1, 3'd2, 7'h7F, 0, 0);
        push(3'd2, 4'h8, 1'b0, 1'b0);
        cyc(1, 3'd2, 7'h7F, 0, 0);
        exp_report("d2_rep");
        for (int i = 0; i < 3; i++) cyc(1, 3'd3, 7'h77, 0, 0);
        chk("ovr_before", overrun, 1'b0);
        cyc(1, 3'd3, 7'h77, 0, 0);
        exp_hold("ovr_hold");
        chk("ovr_set", overrun, 1'b1);
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("ovr_ack");
        chk("ovr_sticky", overrun, 1'b1);

        // Accept coinciding with ack loads the new report without overrun
        cyc(0, 0, 7'h00, 0, 1);
        exp_none("rst2");
        chk("rst2_overrun", overrun, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1, 3'd2, 7'h7F, 0, 0);
        push(3'd2, 4'h8, 1'b0, 1'b0);
        cyc(1, 3'd2, 7'h7F, 0, 0);
        exp_report("d2b_rep");
        for (int i = 0; i < 3; i++) cyc(1, 3'd3, 7'h77, 0, 0);
        push(3'd3, 4'hA, 1'b0, 1'b0);
        cyc(1, 3'd3, 7'h77, 1, 0);
        exp_report("d3_rep");
        chk("d3_overrun", overrun, 1'b0);
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("d3_ack");

        // All-dark digit
        for (int i = 0; i < 3; i++) cyc(1, 3'd0, 7'h00, 0, 0);
`ifdef LED_SEVEN_SEGMENT_READER_BLANK_EN
        push(3'd0, 4'h0, 1'b0, 1'b1);
`else
        push(3'd0, 4'h0, 1'b1, 1'b0);
`endif
        cyc(1, 3'd0, 7'h00, 0, 0);
        exp_report("blank_rep");
        cyc(0, 0, 7'h00, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'd0, 7'h00, 0, 0);
            exp_none("blank_norepeat");
        end

        // Unknown glyph
        for (int i = 0; i < 3; i++) cyc(1, 3'd1, 7'h01, 0, 0);
        push(3'd1, 4'h0, 1'b1, 1'b0);
        cyc(1, 3'd1, 7'h01, 0, 0);
        exp_report("bad_rep");
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("bad_ack");

        // Every glyph, back-to-back with ack on the accepting sample
        for (int h = 0; h < 16; h++) begin
            logic [3:0] hv;
            logic [2:0] dv;
            hv = 4'(h);
            dv = {1'b0, hv[1:0]};
            for (int i = 0; i < 3; i++) cyc(1, dv, pat[h], 0, 0);
            push(dv, hv, 1'b0, 1'b0);
            cyc(1, dv, pat[h], (h > 0), 0);
            exp_report("glyph");
        end
        chk("glyph_overrun", overrun, 1'b0);
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("glyph_ack");

        // Reset discards a held report and a partial count
        for (int i = 0; i < 3; i++) cyc(1, 3'd2, 7'h4F, 0, 0);
        push(3'd2, 4'h3, 1'b0, 1'b0);
        cyc(1, 3'd2, 7'h4F, 0, 0);
        exp_report("pre_rst_rep");
        for (int i = 0; i < 3; i++) cyc(1, 3'd1, 7'h6D, 0, 0);
        cyc(1, 3'd1, 7'h6D, 0, 1);
        exp_none("rst3");
        chk("rst3_overrun", overrun, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd1, 7'h6D, 0, 0);
            exp_none("post_rst");
        end
        push(3'd1, 4'h5, 1'b0, 1'b0);
        cyc(1, 3'd1, 7'h6D, 0, 0);
        exp_report("post_rst_rep");
        cyc(0, 0, 7'h00, 1, 0);
        exp_none("post_rst_ack");

        chk("sb_empty", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
